// File: rtl/audio_mix_sd_dac_pkg.sv
// Shared helpers for the audio mixer: accumulator sizing, shift lookup, saturation.
package audio_mix_sd_dac_pkg;

   // Largest per-channel left shift a 4-bit weight field can express.
   localparam int unsigned SHIFT_MAX = 15;

   // Widest packed SHIFTS vector the lookup helper accepts (32 channels).
   localparam int unsigned SHIFTS_VEC_W = 128;

   // Accumulator width that holds CHANNELS maximally shifted inputs without overflow.
   function automatic int unsigned acc_width(input int unsigned in_w, input int unsigned channels);
      return in_w + SHIFT_MAX + $clog2(channels + 1);
   endfunction

   // Channel-index width; a single channel still needs one bit of storage.
   function automatic int unsigned idx_width(input int unsigned channels);
      return (channels > 1) ? $clog2(channels) : 1;
   endfunction

   // Left-shift weight of channel k; ch0 lives in bits [3:0].
   function automatic logic [3:0] shift_of(input logic [SHIFTS_VEC_W-1:0] shifts, input int unsigned k);
      return shifts[4*k +: 4];
   endfunction

   // Unsigned saturation of value to out_w bits.
   function automatic logic [63:0] sat_u(input logic [63:0] value, input int unsigned out_w);
      logic [63:0] lim;
      lim = (64'd1 << out_w) - 64'd1;
      return (value > lim) ? lim : value;
   endfunction

endpackage

// File: rtl/audio_mix_sd_dac_if.sv
// Mixer data bus: channel inputs and controls in, mixed sample and bitstream out.
interface audio_mix_sd_dac_if #(
   parameter int unsigned CHANNELS = 2,
   parameter int unsigned IN_W     = 8,
   parameter int unsigned OUT_W    = 11
);
   logic [CHANNELS*IN_W-1:0] dat_i;
   logic [2:0]               vol_i;
   logic                     mute_i;
   logic [OUT_W-1:0]         sample_o;
   logic                     sample_vld_o;
   logic                     dac_o;

   modport master (
      output dat_i, vol_i, mute_i,
      input  sample_o, sample_vld_o, dac_o
   );

   modport slave (
      input  dat_i, vol_i, mute_i,
      output sample_o, sample_vld_o, dac_o
   );
endinterface

// File: rtl/audio_mix_sd_dac_sigma_delta_dac.sv
// First-order sigma-delta DAC: the accumulator carry is the output bitstream.
module sigma_delta_dac #(
   parameter int unsigned OUT_W = 11
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic [OUT_W-1:0] din,
   output logic             dout
);
   logic [OUT_W-1:0] sd_acc_q, sd_acc_d;
   logic             dout_q, dout_d;

   // Add the sample into the error accumulator; the overflow carry is the next bit.
   always_comb begin
      {dout_d, sd_acc_d} = {1'b0, sd_acc_q} + {1'b0, din};
   end

   // Accumulator and registered output bit.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         sd_acc_q <= '0;
         dout_q   <= 1'b0;
      end else begin
         sd_acc_q <= sd_acc_d;
         dout_q   <= dout_d;
      end
   end

   assign dout = dout_q;
endmodule

// File: rtl/audio_mix_sd_dac.sv
// N-channel weighted audio mixer with saturation, volume, mute and sigma-delta output.
module audio_mix_sd_dac
   import audio_mix_sd_dac_pkg::*;
#(
   parameter int unsigned           CHANNELS = 2,
   parameter int unsigned           IN_W     = 8,
   parameter int unsigned           OUT_W    = 11,
   parameter logic [4*CHANNELS-1:0] SHIFTS   = {4'd2, 4'd0}
) (
   input  logic          clk_sys,
   input  logic          reset,
   audio_mix_sd_dac_if.slave bus
);
   localparam int unsigned ACC_W = acc_width(IN_W, CHANNELS);
   localparam int unsigned CH_W  = idx_width(CHANNELS);
   localparam logic [CH_W-1:0]         LAST_CH  = CH_W'(CHANNELS - 1);
   localparam logic [SHIFTS_VEC_W-1:0] SHIFTS_X = SHIFTS_VEC_W'(SHIFTS);

   logic [CH_W-1:0]  ch_idx_q, ch_idx_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic             primed_q, primed_d;
   logic [OUT_W-1:0] sample_q, sample_d;
   logic             sample_vld_q, sample_vld_d;
   logic [ACC_W-1:0] term;
   logic [63:0]      sat;

   // Sequencer, accumulator and output stage. The output register consumes the
   // completed sum while slot 0 of the next period is already accumulating, so
   // primed_q blocks a bogus strobe in the very first period after reset.
   always_comb begin
      term = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (ch_idx_q == CH_W'(k)) begin
            term = ACC_W'(bus.dat_i[k*IN_W +: IN_W]) << shift_of(SHIFTS_X, k);
         end
      end

      ch_idx_d = (ch_idx_q == LAST_CH) ? '0 : ch_idx_q + CH_W'(1);
      acc_d    = ((ch_idx_q == '0) ? '0 : acc_q) + term;
      primed_d = primed_q | (ch_idx_q == LAST_CH);

      sat          = sat_u(64'(acc_q), OUT_W);
      sample_d     = sample_q;
      sample_vld_d = 1'b0;
      if ((ch_idx_q == '0) && primed_q) begin
         sample_vld_d = 1'b1;
         sample_d     = bus.mute_i ? '0 : OUT_W'(sat >> bus.vol_i);
      end
   end

   // Mixer state registers.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         ch_idx_q     <= '0;
         acc_q        <= '0;
         primed_q     <= 1'b0;
         sample_q     <= '0;
         sample_vld_q <= 1'b0;
      end else begin
         ch_idx_q     <= ch_idx_d;
         acc_q        <= acc_d;
         primed_q     <= primed_d;
         sample_q     <= sample_d;
         sample_vld_q <= sample_vld_d;
      end
   end

   assign bus.sample_o     = sample_q;
   assign bus.sample_vld_o = sample_vld_q;

   sigma_delta_dac #(.OUT_W(OUT_W)) u_dac (
      .clk_sys (clk_sys),
      .reset   (reset),
      .din     (sample_q),
      .dout    (bus.dac_o)
   );
endmodule

// File: tb/tb_audio_mix_sd_dac.sv
// Self-checking bench: three mixer configurations against a slot-level reference model.
module tb_audio_mix_sd_dac;
   logic clk = 1'b0;
   logic rst = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   int mon_n = 0;               // index of the next post-reset edge of bus0
   logic [10:0] exp_sample = '0;
   logic        exp_vld    = 1'b0;

   always #5 clk = ~clk;

   audio_mix_sd_dac_if #(.CHANNELS(2), .IN_W(8), .OUT_W(11)) bus0 ();
   audio_mix_sd_dac_if #(.CHANNELS(2), .IN_W(8), .OUT_W(10)) bus1 ();
   audio_mix_sd_dac_if #(.CHANNELS(1), .IN_W(8), .OUT_W(11)) bus2 ();

   audio_mix_sd_dac #(.CHANNELS(2), .IN_W(8), .OUT_W(11), .SHIFTS({4'd2, 4'd0})) u0 (
      .clk_sys(clk), .reset(rst), .bus(bus0));
   audio_mix_sd_dac #(.CHANNELS(2), .IN_W(8), .OUT_W(10), .SHIFTS({4'd2, 4'd0})) u1 (
      .clk_sys(clk), .reset(rst), .bus(bus1));
   audio_mix_sd_dac #(.CHANNELS(1), .IN_W(8), .OUT_W(11), .SHIFTS(4'd0)) u2 (
      .clk_sys(clk), .reset(rst), .bus(bus2));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic count_dac(input int sel, input int cycles, output int ones);
      ones = 0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         case (sel)
            0:       ones += int'(bus0.dac_o);
            1:       ones += int'(bus1.dac_o);
            default: ones += int'(bus2.dac_o);
         endcase
      end
   endtask

   // Reference model for bus0: channel k is taken at post-reset edge n with n%2==k;
   // a finished period (edges n-2, n-1) is weighted, saturated and attenuated at edge n.
   initial begin
      logic [15:0] hist [4];
      int sum, sat;
      forever begin
         @(posedge clk);
         if (rst) begin
            mon_n      = 0;
            exp_sample = '0;
            exp_vld    = 1'b0;
         end else begin
            hist[mon_n % 4] = bus0.dat_i;
            exp_vld = (mon_n >= 2) && (mon_n % 2 == 0);
            if (exp_vld) begin
               sum = int'(hist[(mon_n - 2) % 4][7:0]) + 4 * int'(hist[(mon_n - 1) % 4][15:8]);
               sat = (sum > 2047) ? 2047 : sum;
               exp_sample = bus0.mute_i ? 11'd0 : 11'(sat >> bus0.vol_i);
            end
            mon_n++;
         end
         #1;
         check("mon_vld", 64'(bus0.sample_vld_o), 64'(exp_vld));
         check("mon_sample", 64'(bus0.sample_o), 64'(exp_sample));
         if (rst) check("mon_dac_rst", 64'(bus0.dac_o), 64'd0);
      end
   end

   initial begin
      int ones;
      bus0.dat_i = {8'd255, 8'd255}; bus0.vol_i = 3'd0; bus0.mute_i = 1'b0;
      bus1.dat_i = {8'd255, 8'd255}; bus1.vol_i = 3'd0; bus1.mute_i = 1'b0;
      bus2.dat_i = 8'hAA;            bus2.vol_i = 3'd0; bus2.mute_i = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_sample1", 64'(bus1.sample_o), 64'd0);
      check("rst_vld2", 64'(bus2.sample_vld_o), 64'd0);
      check("rst_dac2", 64'(bus2.dac_o), 64'd0);
      @(negedge clk) rst = 1'b0;

      // single channel: strobe every cycle after the first
      @(posedge clk); #1;
      check("c1_first_vld", 64'(bus2.sample_vld_o), 64'd0);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("c1_vld", 64'(bus2.sample_vld_o), 64'd1);
         check("c1_sample", 64'(bus2.sample_o), 64'd170);
      end

      // full-scale inputs: 255 + 4*255
      repeat (6) @(posedge clk);
      #1 check("sum_1275", 64'(bus0.sample_o), 64'd1275);
      count_dac(0, 2048, ones);
      check("ones_1275", 64'(ones), 64'd1275);

      // 10-bit variant saturates
      check("sat_1023", 64'(bus1.sample_o), 64'd1023);
      count_dac(1, 1024, ones);
      check("ones_1023", 64'(ones), 64'd1023);

      // sample 1024, then volume change in mid-period
      @(negedge clk) bus0.dat_i = {8'd255, 8'd4};
      repeat (8) @(posedge clk);
      #1 check("sum_1024", 64'(bus0.sample_o), 64'd1024);
      count_dac(0, 2048, ones);
      check("ones_1024", 64'(ones), 64'd1024);
      @(negedge clk);
      while (mon_n % 2 != 1) @(negedge clk);
      bus0.vol_i = 3'd1;
      @(posedge clk); #1;
      check("vol_hold", 64'(bus0.sample_o), 64'd1024);
      @(posedge clk); #1;
      check("vol_apply_vld", 64'(bus0.sample_vld_o), 64'd1);
      check("vol_apply", 64'(bus0.sample_o), 64'd512);
      repeat (4) @(posedge clk);
      count_dac(0, 2048, ones);
      check("ones_512", 64'(ones), 64'd512);

      // mute: sample goes to 0 and the bitstream drains to all zeros
      @(negedge clk) begin bus0.mute_i = 1'b1; bus0.vol_i = 3'd0; end
      repeat (6) @(posedge clk);
      #1 check("mute_sample", 64'(bus0.sample_o), 64'd0);
      count_dac(0, 2048, ones);
      check("mute_ones", 64'(ones), 64'd0);

      // reset pulse while channel 1 is being accumulated
      @(negedge clk) begin bus0.mute_i = 1'b0; bus0.dat_i = {8'h5C, 8'h37}; end
      repeat (6) @(posedge clk);
      @(negedge clk);
      while (mon_n % 2 != 1) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_sample", 64'(bus0.sample_o), 64'd0);
      check("midrst_vld", 64'(bus0.sample_vld_o), 64'd0);
      check("midrst_dac", 64'(bus0.dac_o), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("postrst_quiet", 64'(bus0.sample_vld_o), 64'd0);
      end
      @(posedge clk); #1;
      check("postrst_vld", 64'(bus0.sample_vld_o), 64'd1);
      check("postrst_sum", 64'(bus0.sample_o), 64'd423);

      // randomized traffic; bus0 is checked every cycle by the model
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         bus0.dat_i = 16'($urandom);
         if ($urandom_range(0, 15) == 0) bus0.vol_i = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 15) == 0) bus0.mute_i = ($urandom_range(0, 7) == 0);
      end
      @(posedge clk); #2;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
